// File: rtl/dmi_pkg.sv
// rtl/dmi_pkg.sv - shared types and constants for the DMI responder
// Contents: op/resp/state enums, register addresses, dmstatus value,
//           abstractcs field positions and a helper that packs abstractcs.
package dmi_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        RESP_OK   = 2'd0,
        RESP_FAIL = 2'd2
    } dmi_resp_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } dmi_state_e;

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;

    localparam logic [31:0] DMSTATUS_VALUE = 32'h0000_0082;

    localparam int ABSCS_BUSY_BIT   = 12;
    localparam int ABSCS_CMDERR_LSB = 8;
    localparam int ABSCS_CMDERR_MSB = 10;
    localparam logic [3:0] ABSCS_DATACOUNT = 4'd1;

    function automatic logic [31:0] abstractcs_word(input logic busy, input logic [2:0] cmderr);
        logic [31:0] w;
        w = '0;
        w[ABSCS_BUSY_BIT] = busy;
        w[ABSCS_CMDERR_MSB:ABSCS_CMDERR_LSB] = cmderr;
        w[3:0] = ABSCS_DATACOUNT;
        return w;
    endfunction

endpackage

// File: rtl/dmi_abscmd_timer.sv
// rtl/dmi_abscmd_timer.sv - abstract command busy counter and cmderr tracking
// Ports: clk, reset (async, active-low); active (dmactive as it will be after
//        this edge); cmd_wr / data0_wr (accepted writes to command / data0);
//        cmderr_clr_en + cmderr_clr (W1C write to abstractcs.cmderr);
//        busy (combinational from counter), cmderr.
module dmi_abscmd_timer #(
    parameter int unsigned CMD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic       cmd_wr,
    input  logic       data0_wr,
    input  logic       cmderr_clr_en,
    input  logic [2:0] cmderr_clr,
    output logic       busy,
    output logic [2:0] cmderr
);

    logic [7:0] count;

    assign busy = (count != 8'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 8'd0;
            cmderr <= 3'd0;
        end else if (!active) begin
            count  <= 8'd0;
            cmderr <= 3'd0;
        end else begin
            // A new command only starts from a clean, idle state.
            if (cmd_wr && !busy && (cmderr == 3'd0)) begin
                count <= 8'(CMD_CYCLES);
            end else if (busy) begin
                count <= count - 8'd1;
            end

            // Touching command/data0 mid-command is a "busy" error; the first
            // error sticks until software clears it.
            if ((cmd_wr || data0_wr) && busy) begin
                if (cmderr == 3'd0) begin
                    cmderr <= 3'd1;
                end
            end else if (cmderr_clr_en) begin
                cmderr <= cmderr & ~cmderr_clr;
            end
        end
    end

endmodule

// File: rtl/dmi_responder.sv
// rtl/dmi_responder.sv - DMI request/response target with a minimal debug register file
// Ports: clk, reset (async, active-low); debug_req_* request channel
//        (valid/ready, addr[6:0], op[1:0], data[31:0]); debug_resp_* response
//        channel (valid/ready, resp[1:0], data[31:0]); dmactive, ndmreset,
//        haltreq dmcontrol mirrors; cmd_busy abstract command in progress.
module dmi_responder
    import dmi_pkg::*;
#(
    parameter int unsigned CMD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        debug_req_valid,
    output logic        debug_req_ready,
    input  logic [6:0]  debug_req_bits_addr,
    input  logic [1:0]  debug_req_bits_op,
    input  logic [31:0] debug_req_bits_data,
    output logic        debug_resp_valid,
    input  logic        debug_resp_ready,
    output logic [1:0]  debug_resp_bits_resp,
    output logic [31:0] debug_resp_bits_data,
    output logic        dmactive,
    output logic        ndmreset,
    output logic        haltreq,
    output logic        cmd_busy
);

    dmi_state_e  state;
    logic [31:0] data0;
    logic [2:0]  cmderr;
    logic [31:0] rd_word;
    logic        accept;
    logic        wr;
    logic        wr_dmcontrol;
    logic        dmactive_nxt;

    // ready is only ever high in IDLE, so this is the IDLE handshake.
    assign accept       = debug_req_ready && debug_req_valid;
    assign wr           = accept && (debug_req_bits_op == OP_WRITE);
    assign wr_dmcontrol = wr && (debug_req_bits_addr == ADDR_DMCONTROL);

    // Clearing logic keys off the post-write dmactive so that writing
    // dmactive=0 clears everything on the same edge.
    assign dmactive_nxt = wr_dmcontrol ? debug_req_bits_data[0] : dmactive;

    dmi_abscmd_timer #(
        .CMD_CYCLES(CMD_CYCLES)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .active        (dmactive_nxt),
        .cmd_wr        (wr && dmactive && (debug_req_bits_addr == ADDR_COMMAND)),
        .data0_wr      (wr && dmactive && (debug_req_bits_addr == ADDR_DATA0)),
        .cmderr_clr_en (wr && dmactive && (debug_req_bits_addr == ADDR_ABSTRACTCS)),
        .cmderr_clr    (debug_req_bits_data[ABSCS_CMDERR_MSB:ABSCS_CMDERR_LSB]),
        .busy          (cmd_busy),
        .cmderr        (cmderr)
    );

    always_comb begin
        rd_word = '0;
        case (debug_req_bits_addr)
            ADDR_DATA0:      rd_word = data0;
            ADDR_DMCONTROL: begin
                rd_word[31] = haltreq;
                rd_word[1]  = ndmreset;
                rd_word[0]  = dmactive;
            end
            ADDR_DMSTATUS:   rd_word = DMSTATUS_VALUE;
            ADDR_ABSTRACTCS: rd_word = abstractcs_word(cmd_busy, cmderr);
            default:         rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmactive <= 1'b0;
            ndmreset <= 1'b0;
            haltreq  <= 1'b0;
            data0    <= '0;
        end else begin
            dmactive <= dmactive_nxt;
            if (wr_dmcontrol) begin
                ndmreset <= debug_req_bits_data[1] & debug_req_bits_data[0];
                haltreq  <= debug_req_bits_data[31] & debug_req_bits_data[0];
            end
            if (!dmactive_nxt) begin
                data0 <= '0;
            end else if (wr && (debug_req_bits_addr == ADDR_DATA0) && !cmd_busy) begin
                data0 <= debug_req_bits_data;
            end
        end
    end

    // ready comes up one edge after reset release even though state is IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= ST_IDLE;
            debug_req_ready      <= 1'b0;
            debug_resp_valid     <= 1'b0;
            debug_resp_bits_resp <= RESP_OK;
            debug_resp_bits_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    debug_req_ready <= 1'b1;
                    if (accept) begin
                        debug_req_ready  <= 1'b0;
                        debug_resp_valid <= 1'b1;
                        state            <= ST_RESP;
                        case (dmi_op_e'(debug_req_bits_op))
                            OP_READ: begin
                                debug_resp_bits_resp <= RESP_OK;
                                debug_resp_bits_data <= rd_word;
                            end
                            OP_RSVD: begin
                                debug_resp_bits_resp <= RESP_FAIL;
                                debug_resp_bits_data <= '0;
                            end
                            default: begin
                                debug_resp_bits_resp <= RESP_OK;
                                debug_resp_bits_data <= '0;
                            end
                        endcase
                    end
                end
                ST_RESP: begin
                    if (debug_resp_ready) begin
                        debug_resp_valid <= 1'b0;
                        debug_req_ready  <= 1'b1;
                        state            <= ST_IDLE;
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    debug_req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmi_responder.md
DMI_RESPONDER -- requirements
Module: dmi_responder

Interface
REQ-001 Parameter CMD_CYCLES, default 4, sets the busy duration in cycles of an abstract command; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous assert, active-low (0 = in reset).
REQ-004 debug_req_valid  input  1  DMI request valid.
REQ-005 debug_req_ready  output  1  responder can accept a request.
REQ-006 debug_req_bits_addr  input  7  DMI register address.
REQ-007 debug_req_bits_op  input  2  0 nop, 1 read, 2 write, 3 reserved.
REQ-008 debug_req_bits_data  input  32  write data.
REQ-009 debug_resp_valid  output  1  response valid.
REQ-010 debug_resp_ready  input  1  initiator accepts response.
REQ-011 debug_resp_bits_resp  output  2  0 success, 2 failed.
REQ-012 debug_resp_bits_data  output  32  read data; 0 for non-read ops.
REQ-013 dmactive, ndmreset, haltreq  output  1 each  mirrors of dmcontrol bits 0, 1, 31.
REQ-014 cmd_busy  output  1  abstract command in progress.

Function
REQ-015 FSM states IDLE, RESP; IDLE drives debug_req_ready=1, RESP drives debug_resp_valid=1; nothing else asserts either signal.
REQ-016 IDLE with debug_req_valid=1 -> request accepted, registers updated, response latched, RESP next cycle (1-cycle latency).
REQ-017 RESP with debug_resp_ready=1 -> IDLE next cycle; response fields held stable while debug_resp_valid=1 and ready=0.
REQ-018 No request accepted in the cycle a response completes; peak throughput one transaction per 2 cycles.
REQ-019 Address map: 0x04 data0 RW32; 0x10 dmcontrol (bit0 dmactive, bit1 ndmreset, bit31 haltreq RW, other bits read 0); 0x11 dmstatus RO = 32'h0000_0082; 0x16 abstractcs (bit12 busy RO, bits10:8 cmderr W1C, bits3:0 datacount RO = 1); 0x17 command, write-only, reads 0.
REQ-020 Unmapped address: read returns 0, write ignored, resp 0.
REQ-021 Op 3: no state change, resp 2, data 0; op 0: no state change, resp 0, data 0.
REQ-022 Write to command with busy=0, cmderr=0, dmactive=1 -> busy=1 for exactly CMD_CYCLES cycles via 8-bit down-counter, then busy=0.
REQ-023 Write to command or data0 while busy=1 -> write discarded; cmderr set to 1 only if cmderr was 0; resp 0.
REQ-024 Write to command while cmderr!=0 -> ignored, no busy.
REQ-025 dmactive=0 -> data0, cmderr, busy counter, ndmreset, haltreq forced 0; writes to any register except dmcontrol ignored; dmcontrol write updates all three bits in the same cycle.
REQ-026 Read of abstractcs in the cycle the counter expires returns busy=0.
REQ-027 cmd_busy equals abstractcs.busy combinationally from the counter register.

Reset
REQ-028 reset=0 asynchronously forces IDLE, debug_req_ready=0 while asserted, debug_resp_valid=0, resp/data outputs 0, all registers and counter 0, dmactive=ndmreset=haltreq=cmd_busy=0.
REQ-029 Reset asserted in RESP discards the pending response; debug_req_ready=1 on the first clk edge after deassertion.

Structure
REQ-030 Package dmi_pkg holds op and resp enums, address constants, the dmstatus value and abstractcs field positions.
REQ-031 Sub-module dmi_abscmd_timer holds the busy counter, cmderr and start/error logic; all else in dmi_responder.

Verification
REQ-032 Write 0x04 = 0xDEADBEEF with dmactive=0 -> resp 0; read 0x04 -> 0x00000000.
REQ-033 Write 0x10 = 0x80000003, read 0x10 -> 0x80000003; dmactive=ndmreset=haltreq=1.
REQ-034 Command write with CMD_CYCLES=4 -> cmd_busy high exactly 4 cycles; abstractcs read mid-busy -> 0x00001001.
REQ-035 Write data0 while busy -> abstractcs reads 0x00000101; write 0x00000700 to 0x16 -> reads 0x00000001.
REQ-036 Op 3 to 0x04 -> resp 2; read 0x7F -> resp 0, data 0; resp_ready held low 5 cycles -> outputs stable, req_ready=0 throughout.
REQ-037 Reset asserted mid-RESP -> debug_resp_valid=0 immediately; after release all reads return reset values.
